lcd_text_writer: RTL and testbench

- Consumes the 256-bit, 32-character ASCII screen image produced by the room/state logic.
- Drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus.
- Runs the power-up init sequence, then repeatedly redraws both lines from a per-frame snapshot of the input, so room changes appear without tearing.

---
 rtl/lcd_text_writer.sv | 172 +++++++++++++++++
 tb/tb_lcd_text_writer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// HD44780 16x2 text writer: power-up wait, init sequence, then continuous
// two-line redraw from a per-frame snapshot of the 32-character screen image.
module lcd_text_writer #(
    parameter int unsigned POWERUP_WAIT = 750000,
    parameter int unsigned E_HIGH       = 25,
    parameter int unsigned CMD_WAIT     = 2500,
    parameter int unsigned CLEAR_WAIT   = 100000
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic [255:0] characters,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_E,
    output logic [7:0]   LCD_DATA,
    output logic         ready,
    output logic         frame_done
);

    typedef enum logic [2:0] {
        POWER_WAIT,
        INIT,
        LINE1_ADDR,
        LINE1_CHARS,
        LINE2_ADDR,
        LINE2_CHARS
    } state_t;

    typedef enum logic [1:0] {
        SETUP,
        PULSE,
        HOLD
    } phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [31:0]      cnt, cnt_n;
    logic [1:0]       init_idx, init_n;
    logic [3:0]       col, col_n;
    logic             ready_n, frame_end, snap_en, txn_done;
    logic [31:0]      hold_len;
    logic [31:0][7:0] snap;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign LCD_RW   = 1'b0;
    assign hold_len = (state == INIT && init_idx == 2'd3) ? CLEAR_WAIT : CMD_WAIT;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state      <= POWER_WAIT;
            phase      <= SETUP;
            cnt        <= '0;
            init_idx   <= '0;
            col        <= '0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            init_idx   <= init_n;
            col        <= col_n;
            ready      <= ready_n;
            frame_done <= frame_end;
        end
    end

    // Packed element 31 holds bits [255:248], i.e. line 1 column 0.
    always_ff @(posedge CLK) begin
        if (snap_en)
            snap <= characters;
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt + 32'd1;
        init_n    = init_idx;
        col_n     = col;
        ready_n   = ready;
        snap_en   = 1'b0;
        frame_end = 1'b0;
        txn_done  = 1'b0;
        if (state == POWER_WAIT) begin
            if (cnt == POWERUP_WAIT - 1) begin
                state_n = INIT;
                phase_n = SETUP;
                cnt_n   = '0;
            end
        end else begin
            unique case (phase)
                SETUP: begin
                    phase_n = PULSE;
                    cnt_n   = '0;
                end
                PULSE: if (cnt == E_HIGH - 1) begin
                    phase_n = HOLD;
                    cnt_n   = '0;
                end
                HOLD: if (cnt == hold_len - 32'd1) begin
                    phase_n  = SETUP;
                    cnt_n    = '0;
                    txn_done = 1'b1;
                end
                default: begin
                    phase_n = SETUP;
                    cnt_n   = '0;
                end
            endcase
        end
        // The 4-bit column wraps 15 -> 0 on the same edge that leaves the line.
        if (txn_done) begin
            unique case (state)
                INIT: begin
                    init_n = init_idx + 2'd1;
                    if (init_idx == 2'd3) begin
                        state_n = LINE1_ADDR;
                        snap_en = 1'b1;
                        ready_n = 1'b1;
                    end
                end
                LINE1_ADDR: state_n = LINE1_CHARS;
                LINE1_CHARS: begin
                    col_n = col + 4'd1;
                    if (col == 4'd15)
                        state_n = LINE2_ADDR;
                end
                LINE2_ADDR: state_n = LINE2_CHARS;
                LINE2_CHARS: begin
                    col_n = col + 4'd1;
                    if (col == 4'd15) begin
                        state_n   = LINE1_ADDR;
                        snap_en   = 1'b1;
                        frame_end = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        LCD_RS   = 1'b0;
        LCD_DATA = '0;
        LCD_E    = 1'b0;
        unique case (state)
            INIT:       LCD_DATA = init_cmd(init_idx);
            LINE1_ADDR: LCD_DATA = 8'h80;
            LINE1_CHARS: begin
                LCD_RS   = 1'b1;
                LCD_DATA = snap[5'd31 - {1'b0, col}];
            end
            LINE2_ADDR: LCD_DATA = 8'hC0;
            LINE2_CHARS: begin
                LCD_RS   = 1'b1;
                LCD_DATA = snap[5'd31 - {1'b1, col}];
            end
            default: ;
        endcase
        if (state != POWER_WAIT && phase == PULSE)
            LCD_E = 1'b1;
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer: bus transactions are captured on
// E falling edges and compared with a screen-layout model of each frame.
module tb_lcd_text_writer;

    localparam int unsigned PW        = 10;
    localparam int unsigned EH        = 2;
    localparam int unsigned CW        = 4;
    localparam int unsigned CLW       = 8;
    localparam int unsigned TXN       = 1 + EH + CW;
    localparam int unsigned FRAME_CYC = 34 * TXN;

    logic         CLK = 1'b0;
    logic         Reset_n = 1'b0;
    logic [255:0] characters;
    logic         LCD_RS, LCD_RW, LCD_E, ready, frame_done;
    logic [7:0]   LCD_DATA;

    lcd_text_writer #(
        .POWERUP_WAIT(PW),
        .E_HIGH(EH),
        .CMD_WAIT(CW),
        .CLEAR_WAIT(CLW)
    ) dut (
        .CLK(CLK),
        .Reset_n(Reset_n),
        .characters(characters),
        .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW),
        .LCD_E(LCD_E),
        .LCD_DATA(LCD_DATA),
        .ready(ready),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rs;
        logic [7:0]  data;
        logic [31:0] fall;
        logic [31:0] width;
        logic        stable;
    } ev_t;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc++;

    ev_t         evq[$];
    int unsigned fdq[$];
    ev_t         mon_ev;
    logic        prev_e = 1'b0, prev_fd = 1'b0, prev_ready = 1'b0;
    logic        rise_rs;
    logic [7:0]  rise_data;
    int unsigned rise_cyc = 0, ready_cyc = 0, fd_long = 0;

    always @(posedge CLK) begin
        #1;
        if (LCD_E === 1'b1 && prev_e !== 1'b1) begin
            rise_cyc  = cyc;
            rise_rs   = LCD_RS;
            rise_data = LCD_DATA;
        end
        if (LCD_E === 1'b0 && prev_e === 1'b1) begin
            mon_ev.rs     = LCD_RS;
            mon_ev.data   = LCD_DATA;
            mon_ev.fall   = cyc;
            mon_ev.width  = cyc - rise_cyc;
            mon_ev.stable = (LCD_RS === rise_rs) && (LCD_DATA === rise_data);
            evq.push_back(mon_ev);
        end
        if (frame_done === 1'b1 && prev_fd !== 1'b1) fdq.push_back(cyc);
        if (frame_done === 1'b1 && prev_fd === 1'b1) fd_long++;
        if (ready === 1'b1 && prev_ready !== 1'b1) ready_cyc = cyc;
        prev_e     = LCD_E;
        prev_fd    = frame_done;
        prev_ready = ready;
    end

    int           vectors = 0, miscompares = 0;
    int unsigned  rel_cyc;
    logic [255:0] cur_img;
    logic [255:0] cave_img, twisty_img, alla_img;

    // Frame transaction idx as {rs,data}: 0=80, 1..16 line 1, 17=C0, 18..33 line 2.
    function automatic logic [8:0] model_byte(input logic [255:0] img, input int idx);
        logic [255:0] sh;
        int k;
        if (idx == 0) return {1'b0, 8'h80};
        if (idx == 17) return {1'b0, 8'hC0};
        k  = (idx <= 16) ? idx - 1 : idx - 2;
        sh = img >> (8 * (31 - k));
        return {1'b1, sh[7:0]};
    endfunction

    function automatic logic [255:0] rand_img();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic pop_event(output ev_t e, output bit ok);
        int unsigned budget = 4 * TXN + CLW;
        while (evq.size() == 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        ok = (evq.size() != 0);
        e  = ok ? evq.pop_front() : '0;
    endtask

    task automatic collect_frame(input int sw, input logic [255:0] nimg,
                                 output ev_t got [34], output bit ok);
        bit got_ok;
        ok = 1'b1;
        for (int i = 0; i < 34; i++) got[i] = '0;
        for (int i = 0; i < 34; i++) begin
            pop_event(got[i], got_ok);
            if (!got_ok) begin
                ok = 1'b0;
                break;
            end
            if (i == sw) characters = nimg;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++; if (LCD_E !== 1'b0) begin miscompares++; $display("FAIL reset_E: got %b expected 0", LCD_E); end
        vectors++; if (LCD_RS !== 1'b0) begin miscompares++; $display("FAIL reset_RS: got %b expected 0", LCD_RS); end
        vectors++; if (LCD_RW !== 1'b0) begin miscompares++; $display("FAIL reset_RW: got %b expected 0", LCD_RW); end
        vectors++; if (LCD_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_DATA: got %h expected 00", LCD_DATA); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        @(negedge CLK);
        evq.delete();
        fdq.delete();
        ready_cyc = 0;
        fd_long   = 0;
    endtask

    task automatic test_power_wait();
        Reset_n = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < PW; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if (LCD_E !== 1'b0) begin miscompares++; $display("FAIL power_wait_E[%0d]: got %b expected 0", i, LCD_E); end
        end
        vectors++; if (LCD_DATA !== 8'h38) begin miscompares++; $display("FAIL first_setup_DATA: got %h expected 38", LCD_DATA); end
        vectors++; if (LCD_RS !== 1'b0) begin miscompares++; $display("FAIL first_setup_RS: got %b expected 0", LCD_RS); end
        for (int i = 0; i < EH; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if (LCD_E !== 1'b1) begin miscompares++; $display("FAIL first_pulse_E[%0d]: got %b expected 1", i, LCD_E); end
        end
        @(posedge CLK); #1;
        vectors++; if (LCD_E !== 1'b0) begin miscompares++; $display("FAIL first_pulse_end_E: got %b expected 0", LCD_E); end
        @(negedge CLK);
        vectors++;
        if (evq.size() != 1) begin
            miscompares++; $display("FAIL first_pulse_count: got %0d expected 1", evq.size());
        end else if (evq[0].fall != rel_cyc + PW + 1 + EH) begin
            miscompares++; $display("FAIL first_pulse_time: got %0d expected %0d", evq[0].fall, rel_cyc + PW + 1 + EH);
        end
    endtask

    task automatic test_init();
        logic [7:0]  exp_cmd [4];
        ev_t         e [4];
        int unsigned budget;
        exp_cmd = '{8'h38, 8'h0C, 8'h06, 8'h01};
        budget = 200;
        while (evq.size() < 4 && budget > 0) begin @(negedge CLK); budget--; end
        vectors++;
        if (evq.size() < 4) begin
            miscompares++; $display("FAIL init_timeout: got %0d events expected 4", evq.size());
            return;
        end
        for (int i = 0; i < 4; i++) e[i] = evq.pop_front();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({e[i].rs, e[i].data} !== {1'b0, exp_cmd[i]}) begin
                miscompares++; $display("FAIL init_cmd[%0d]: got rs=%b data=%h expected rs=0 data=%h", i, e[i].rs, e[i].data, exp_cmd[i]);
            end
            vectors++;
            if (e[i].width != EH || e[i].stable !== 1'b1) begin
                miscompares++; $display("FAIL init_pulse[%0d]: got width=%0d stable=%b expected width=%0d stable=1", i, e[i].width, e[i].stable, EH);
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (e[i+1].fall - e[i].fall != TXN) begin
                miscompares++; $display("FAIL init_spacing[%0d]: got %0d expected %0d", i, e[i+1].fall - e[i].fall, TXN);
            end
        end
        budget = 50;
        while (ready_cyc == 0 && budget > 0) begin @(negedge CLK); budget--; end
        vectors++;
        if (ready_cyc == 0) begin
            miscompares++; $display("FAIL ready_rise: got never expected after clear");
        end else if (ready_cyc - (e[3].fall - (1 + EH)) != 1 + EH + CLW) begin
            miscompares++; $display("FAIL ready_rise: got %0d cycles after clear setup expected %0d", ready_cyc - (e[3].fall - (1 + EH)), 1 + EH + CLW);
        end
        vectors++;
        if (fdq.size() != 0) begin miscompares++; $display("FAIL init_frame_done: got %0d pulses expected 0", fdq.size()); end
    endtask

    task automatic test_frame();
        ev_t got [34];
        bit  ok;
        int unsigned budget;
        collect_frame(-1, '0, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL frame1_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL frame1[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
        vectors++;
        if (fdq.size() != 0) begin miscompares++; $display("FAIL frame1_early_done: got %0d pulses expected 0", fdq.size()); end
        collect_frame(-1, '0, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL frame2_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL frame2[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
        vectors++;
        if (fdq.size() < 1) begin
            miscompares++; $display("FAIL frame_done_first: got none expected 1");
        end else if (got[0].fall != fdq[0] + 1 + EH) begin
            miscompares++; $display("FAIL frame_done_align: got 80 fall %0d expected %0d", got[0].fall, fdq[0] + 1 + EH);
        end
        budget = 4 * TXN;
        while (fdq.size() < 2 && budget > 0) begin @(negedge CLK); budget--; end
        vectors++;
        if (fdq.size() < 2) begin
            miscompares++; $display("FAIL frame_period: got %0d pulses expected 2", fdq.size());
        end else if (fdq[1] - fdq[0] != FRAME_CYC) begin
            miscompares++; $display("FAIL frame_period: got %0d expected %0d", fdq[1] - fdq[0], FRAME_CYC);
        end
        vectors++;
        if (fd_long != 0) begin miscompares++; $display("FAIL frame_done_width: got %0d extra high cycles expected 0", fd_long); end
    endtask

    task automatic test_snapshot();
        ev_t got [34];
        bit  ok;
        collect_frame(6, twisty_img, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL snap_cur_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL snap_cur[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
        cur_img = twisty_img;
        collect_frame(-1, '0, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL snap_next_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL snap_next[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
    endtask

    task automatic test_random();
        ev_t          got [34];
        bit           ok;
        logic [255:0] nimg;
        for (int it = 0; it < 4; it++) begin
            nimg = rand_img();
            collect_frame((it < 3) ? int'($urandom_range(33, 0)) : -1, nimg, got, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rand%0d_timeout: got timeout expected 34 events", it); end
            for (int i = 0; i < 34; i++) begin
                vectors++;
                if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                    miscompares++; $display("FAIL rand%0d[%0d]: got %h expected %h", it, i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
                end
            end
            if (it < 3) cur_img = nimg;
        end
    endtask

    task automatic test_wrap();
        ev_t got [34];
        ev_t e;
        bit  ok;
        int  c0_idx, n2, bad;
        collect_frame(int'($urandom_range(33, 0)), alla_img, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_prev_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL wrap_prev[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
        cur_img = alla_img;
        collect_frame(-1, '0, got, ok);
        vectors++;
        if ({got[0].rs, got[0].data} !== 9'h080) begin miscompares++; $display("FAIL wrap_line1_addr: got %h expected 080", {got[0].rs, got[0].data}); end
        c0_idx = 34;
        for (int i = 33; i >= 1; i--) if (got[i].rs === 1'b0) c0_idx = i;
        vectors++;
        if (c0_idx - 1 != 16) begin miscompares++; $display("FAIL wrap_line1_writes: got %0d expected 16", c0_idx - 1); end
        vectors++;
        if (c0_idx < 34 && got[c0_idx].data !== 8'hC0) begin miscompares++; $display("FAIL wrap_line2_addr: got %h expected C0", got[c0_idx].data); end
        n2  = 0;
        bad = 0;
        for (int i = 1; i < 34; i++) begin
            if (i > c0_idx && got[i].rs === 1'b1) n2++;
            if (i != c0_idx && got[i].data !== 8'h41) bad++;
        end
        pop_event(e, ok);
        vectors++;
        if (n2 != 16 || {e.rs, e.data} !== 9'h080) begin
            miscompares++; $display("FAIL wrap_line2_writes: got %0d writes then %h expected 16 then 080", n2, {e.rs, e.data});
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL wrap_data: got %0d non-41 bytes expected 0", bad); end
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL ready_sticky: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        ev_t got [34];
        ev_t e;
        bit  ok, found;
        int unsigned budget;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            pop_event(e, ok);
            if (!ok) break;
            if (e.rs === 1'b0 && e.data === 8'hC0) found = 1'b1;
        end
        for (int n = 0; n < 3; n++) pop_event(e, ok);
        budget = 4 * TXN;
        while (LCD_E !== 1'b1 && budget > 0) begin @(negedge CLK); budget--; end
        vectors++;
        if (!found || LCD_E !== 1'b1) begin
            miscompares++; $display("FAIL midreset_reach: got found=%b E=%b expected 1 1", found, LCD_E);
        end
        Reset_n = 1'b0;
        @(posedge CLK); #1;
        vectors++; if (LCD_E !== 1'b0) begin miscompares++; $display("FAIL midreset_E: got %b expected 0", LCD_E); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b expected 0", ready); end
        vectors++; if ({LCD_RS, LCD_DATA} !== 9'h000) begin miscompares++; $display("FAIL midreset_bus: got %h expected 000", {LCD_RS, LCD_DATA}); end
        @(negedge CLK);
        evq.delete();
        fdq.delete();
        ready_cyc = 0;
        fd_long   = 0;
        test_power_wait();
        test_init();
        collect_frame(-1, '0, got, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL post_reset_timeout: got timeout expected 34 events"); end
        for (int i = 0; i < 34; i++) begin
            vectors++;
            if ({got[i].rs, got[i].data} !== model_byte(cur_img, i)) begin
                miscompares++; $display("FAIL post_reset[%0d]: got %h expected %h", i, {got[i].rs, got[i].data}, model_byte(cur_img, i));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1);
    end

    initial begin
        logic [127:0] l1, l2;
        l1 = "    Cave of     ";
        l2 = "   Cacophany    ";
        cave_img = {l1, l2};
        l1 = " Twisty Tunnel  ";
        l2 = "   of Echoes    ";
        twisty_img = {l1, l2};
        alla_img   = {32{8'h41}};
        characters = cave_img;
        cur_img    = cave_img;
        test_reset();
        test_power_wait();
        test_init();
        test_frame();
        test_snapshot();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
